// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared opcodes, data-memory defaults and E/M register layout
package mips_defs;

  localparam int unsigned DM_WORDS_DEFAULT = 3072;
  localparam logic [31:0] DM_BASE_DEFAULT  = 32'h0000_0000;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] r2;
    logic [31:0] r3;
    logic [4:0]  a_r3;
  } em_reg_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - word-organised data memory, combinational read, byte-enable write, reset-cleared
module dm_ram #(
  parameter int unsigned WORDS = 3072,
  localparam int unsigned AW = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [WORDS];

  assign rdata = (32'(addr) < WORDS) ? mem_q[addr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: E/M register, store lanes, load extension
// Optional MEM_WRITE_LOG_EN prints every committed in-range store (simulation only).
module mem_stage
  import mips_defs::*;
#(
  parameter int unsigned DM_WORDS = DM_WORDS_DEFAULT,
  parameter logic [31:0] DM_BASE  = DM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_M,
  input  logic [31:0] instrE,
  input  logic [31:0] pcE,
  input  logic [31:0] v_ALUout_EM,
  input  logic [31:0] v_R2_EM,
  input  logic [31:0] v_R3_EM,
  input  logic [4:0]  a_R3_EM,
  input  logic [31:0] fwd_st_M,
  output logic [31:0] instrM,
  output logic [31:0] pcM,
  output logic [4:0]  a_R3_M,
  output logic [31:0] v_R2_M,
  output logic [31:0] v_R3_M,
  output logic [31:0] v_R3_MW,
  output logic        h_M
);

  localparam int unsigned AW = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;

  em_reg_t em_d, em_q;

  always_comb begin
    em_d = '0;
    if (!flush_M) begin
      em_d.instr = instrE;
      em_d.pc    = pcE;
      em_d.alu   = v_ALUout_EM;
      em_d.r2    = v_R2_EM;
      em_d.r3    = v_R3_EM;
      em_d.a_r3  = a_R3_EM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) em_q <= '0;
    else       em_q <= em_d;
  end

  assign instrM = em_q.instr;
  assign pcM    = em_q.pc;
  assign a_R3_M = em_q.a_r3;
  assign v_R2_M = em_q.r2;
  assign v_R3_M = em_q.r3;

  logic [5:0]    op;
  logic [31:0]   offset;
  logic [29:0]   word_idx;
  logic          in_range;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic [31:0]   rd_word;

  assign op       = em_q.instr[31:26];
  assign offset   = em_q.alu - DM_BASE;
  assign word_idx = offset[31:2];
  assign in_range = ({2'b00, word_idx} < DM_WORDS);
  // Truncated index can alias a valid word, so in_range gates both read and write.
  assign ram_addr = word_idx[AW-1:0];
  assign rd_word  = in_range ? ram_rdata : '0;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = fwd_st_M;
    case (op)
      OP_SW: st_be = 4'b1111;
      OP_SH: begin
        st_wdata = {2{fwd_st_M[15:0]}};
        st_be    = em_q.alu[1] ? 4'b1100 : 4'b0011;
      end
      OP_SB: begin
        st_wdata = {4{fwd_st_M[7:0]}};
        st_be    = 4'b0001 << em_q.alu[1:0];
      end
      default: st_be = 4'b0000;
    endcase
    if (!in_range) st_be = 4'b0000;
  end

  dm_ram #(.WORDS(DM_WORDS)) u_dm_ram (
    .clk   (clk),
    .reset (reset),
    .addr  (ram_addr),
    .be    (st_be),
    .wdata (st_wdata),
    .rdata (ram_rdata)
  );

  logic [15:0] ld_half;
  logic [7:0]  ld_byte;
  logic [31:0] ld_val;

  assign ld_half = em_q.alu[1] ? rd_word[31:16] : rd_word[15:0];
  assign ld_byte = rd_word[{em_q.alu[1:0], 3'b000} +: 8];

  always_comb begin
    ld_val = rd_word;
    case (op)
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_val = {16'h0000, ld_half};
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_val = {24'h000000, ld_byte};
      default: ld_val = rd_word;
    endcase
  end

  assign h_M     = !is_load(op);
  assign v_R3_MW = h_M ? em_q.r3 : ld_val;

`ifdef MEM_WRITE_LOG_EN
`ifndef SYNTHESIS
  logic [31:0] log_mask;
  assign log_mask = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};

  always @(posedge clk) begin
    if (!reset && (st_be != 4'b0000))
      $display("@%08h: *%08h <= %08h", em_q.pc, {em_q.alu[31:2], 2'b00},
               (ram_rdata & ~log_mask) | (st_wdata & log_mask));
  end
`endif
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed and random checks of mem_stage against a word-array model
module tb_mem_stage;

  localparam int unsigned DW = 64;
  localparam logic [31:0] DB = 32'h0000_0000;

  localparam logic [5:0] NOP = 6'b000000, ADDI = 6'b001000;
  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;

  logic        clk = 1'b0;
  logic        reset, flush_M;
  logic [31:0] instrE, pcE, v_ALUout_EM, v_R2_EM, v_R3_EM, fwd_st_M;
  logic [4:0]  a_R3_EM;
  logic [31:0] instrM, pcM, v_R2_M, v_R3_M, v_R3_MW;
  logic [4:0]  a_R3_M;
  logic        h_M;

  mem_stage #(.DM_WORDS(DW), .DM_BASE(DB)) dut (
    .clk(clk), .reset(reset), .flush_M(flush_M),
    .instrE(instrE), .pcE(pcE), .v_ALUout_EM(v_ALUout_EM),
    .v_R2_EM(v_R2_EM), .v_R3_EM(v_R3_EM), .a_R3_EM(a_R3_EM),
    .fwd_st_M(fwd_st_M),
    .instrM(instrM), .pcM(pcM), .a_R3_M(a_R3_M),
    .v_R2_M(v_R2_M), .v_R3_M(v_R3_M), .v_R3_MW(v_R3_MW), .h_M(h_M)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [DW];
  logic [31:0] m_instr = '0, m_pc = '0, m_alu = '0, m_r2 = '0, m_r3 = '0;
  logic [4:0]  m_a = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic is_ld(input logic [5:0] op);
    return op == LW || op == LH || op == LHU || op == LB || op == LBU;
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'((w >> (8 * addr[1:0])) & 32'hFF);
    h = 16'((w >> (16 * addr[1])) & 32'hFFFF);
    case (op)
      LH:      return 32'($signed(h));
      LHU:     return {16'h0, h};
      LB:      return 32'($signed(b));
      LBU:     return {24'h0, b};
      default: return w;
    endcase
  endfunction

  task automatic check_model();
    logic [5:0]  op;
    logic [31:0] idx, w, exp_mw;
    op  = m_instr[31:26];
    idx = (m_alu - DB) >> 2;
    w   = '0;
    if (idx < DW) w = mm[idx];
    exp_mw = is_ld(op) ? ref_load(op, m_alu, w) : m_r3;
    chk("instrM", instrM, m_instr);
    chk("pcM", pcM, m_pc);
    chk("a_R3_M", {27'h0, a_R3_M}, {27'h0, m_a});
    chk("v_R2_M", v_R2_M, m_r2);
    chk("v_R3_M", v_R3_M, m_r3);
    chk("v_R3_MW", v_R3_MW, exp_mw);
    chk("h_M", {31'h0, h_M}, {31'h0, !is_ld(op)});
  endtask

  task automatic tick();
    logic [5:0]  op;
    logic [31:0] idx, w;
    if (reset) begin
      for (int i = 0; i < DW; i++) mm[i] = '0;
      {m_instr, m_pc, m_alu, m_r2, m_r3, m_a} = '0;
    end else begin
      op  = m_instr[31:26];
      idx = (m_alu - DB) >> 2;
      if (idx < DW) begin
        w = mm[idx];
        case (op)
          SW: w = fwd_st_M;
          SH: if (m_alu[1]) w[31:16] = fwd_st_M[15:0]; else w[15:0] = fwd_st_M[15:0];
          SB: w[8*m_alu[1:0] +: 8] = fwd_st_M[7:0];
          default: ;
        endcase
        mm[idx] = w;
      end
      if (flush_M) {m_instr, m_pc, m_alu, m_r2, m_r3, m_a} = '0;
      else begin
        m_instr = instrE; m_pc = pcE; m_alu = v_ALUout_EM;
        m_r2 = v_R2_EM; m_r3 = v_R3_EM; m_a = a_R3_EM;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] st, input logic fl);
    instrE      = {op, 26'($urandom)};
    pcE         = $urandom;
    v_ALUout_EM = addr;
    v_R2_EM     = $urandom;
    v_R3_EM     = $urandom;
    a_R3_EM     = 5'($urandom);
    fwd_st_M    = st;
    flush_M     = fl;
  endtask

  task automatic step(input logic [5:0] op, input logic [31:0] addr,
                      input logic [31:0] st, input logic fl);
    drive(op, addr, st, fl);
    check_model();
    tick();
  endtask

  task automatic peek(input string tag, input logic [31:0] exp_mw, input logic exp_h);
    chk(tag, v_R3_MW, exp_mw);
    chk({tag, "_h"}, {31'h0, h_M}, {31'h0, exp_h});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_instrM"}, instrM, 32'h0);
    chk({tag, "_pcM"}, pcM, 32'h0);
    chk({tag, "_aR3"}, {27'h0, a_R3_M}, 32'h0);
    chk({tag, "_R2"}, v_R2_M, 32'h0);
    chk({tag, "_R3"}, v_R3_M, 32'h0);
    chk({tag, "_MW"}, v_R3_MW, 32'h0);
    chk({tag, "_h"}, {31'h0, h_M}, 32'h1);
  endtask

  initial begin
    logic [5:0]  ops [10];
    logic [31:0] addr;
    ops = '{NOP, ADDI, LW, LH, LHU, LB, LBU, SW, SH, SB};

    reset = 1'b1;
    drive(SW, 32'h10, 32'hFFFF_FFFF, 1'b0);
    tick();
    tick();
    check_zero("rst0");
    reset = 1'b0;

    step(SW, 32'h10, $urandom, 1'b0);
    step(LW, 32'h10, 32'h1234_5678, 1'b0);
    peek("sw_lw", 32'h1234_5678, 1'b0);

    step(SB, 32'h13, $urandom, 1'b0);
    step(LB, 32'h13, 32'h5A5A_5AAB, 1'b0);
    peek("sb_lb", 32'hFFFF_FFAB, 1'b0);
    step(LBU, 32'h13, $urandom, 1'b0);
    peek("sb_lbu", 32'h0000_00AB, 1'b0);
    step(LW, 32'h10, $urandom, 1'b0);
    peek("sb_word", 32'hAB34_5678, 1'b0);

    step(SH, 32'h12, $urandom, 1'b0);
    step(LH, 32'h12, 32'hDEAD_8001, 1'b0);
    peek("sh_lh", 32'hFFFF_8001, 1'b0);
    step(LHU, 32'h12, $urandom, 1'b0);
    peek("sh_lhu", 32'h0000_8001, 1'b0);

    step(SW, 32'h20, $urandom, 1'b0);
    step(LW, 32'h20, 32'hCAFE_F00D, 1'b1);
    chk("flush_instrM", instrM, 32'h0);
    chk("flush_aR3", {27'h0, a_R3_M}, 32'h0);
    step(LW, 32'h20, $urandom, 1'b0);
    peek("flush_store", 32'hCAFE_F00D, 1'b0);

    step(SW, DB + 4 * DW, $urandom, 1'b0);
    step(LW, DB + 4 * DW, 32'hFFFF_FFFF, 1'b0);
    peek("oor_lw", 32'h0, 1'b0);
    step(LW, DB, $urandom, 1'b0);
    peek("oor_alias", 32'h0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else addr = DB + {$urandom_range(0, DW - 1), 2'($urandom)};
      step(ops[$urandom_range(0, 9)], addr, $urandom, $urandom_range(0, 9) == 0);
    end

    step(SW, 32'h30, $urandom, 1'b0);
    drive(SW, 32'h34, 32'h7777_7777, 1'b0);
    check_model();
    reset = 1'b1;
    tick();
    check_zero("rst1");
    reset = 1'b0;
    for (int i = 0; i < DW; i++) begin
      step(LW, DB + 4 * i, $urandom, 1'b0);
      peek($sformatf("clr%0d", i), 32'h0, 1'b0);
    end
    step(NOP, 32'h0, $urandom, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DM_WORDS, default 3072, meaning data-memory depth in 32-bit words.
REQ-002 SHALL have parameter DM_BASE, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port flush_M  in  1  load a bubble (nop) into the M register.
REQ-007 SHALL have ports instrE, pcE  in  32 each  instruction and PC leaving E.
REQ-008 SHALL have ports v_ALUout_EM, v_R2_EM, v_R3_EM  in  32 each  address, store data, E result.
REQ-009 SHALL have port a_R3_EM  in  5  destination register.
REQ-010 SHALL have port fwd_st_M  in  32  store data after M-level forwarding, from the hazard unit.
REQ-011 SHALL have ports instrM, pcM  out  32 each  registered instruction and PC.
REQ-012 SHALL have port a_R3_M  out  5  registered destination.
REQ-013 SHALL have port v_R2_M  out  32  registered store data, input to the hazard forwarding mux.
REQ-014 SHALL have port v_R3_M  out  32  registered E result, used as the M forwarding source.
REQ-015 SHALL have port v_R3_MW  out  32  write-back value to W: load data for loads, else v_R3_M.
REQ-016 SHALL have port h_M  out  1  high when v_R3_M is valid for forwarding, i.e. instrM is not a load.

Function
REQ-017 SHALL register all E inputs every cycle into the E/M register; no stall input exists.
REQ-018 SHALL load zeros into the E/M register on flush_M, giving instrM=0 (nop) and a_R3_M=0.
REQ-019 SHALL form the word index as (addrM - DM_BASE)>>2, where addrM is the registered ALUout.
REQ-020 SHALL read combinationally; a read outside DM_WORDS SHALL return 0.
REQ-021 SHALL decode loads by opcode: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
REQ-022 SHALL pick the lh/lhu half by addrM[1] and the lb/lbu byte by addrM[1:0], little-endian; lh/lb sign-extend and lhu/lbu zero-extend.
REQ-023 SHALL perform stores at the rising edge that ends the M cycle: sw 101011 all bytes, sh 101001 bytes picked by addrM[1], sb 101000 one byte by addrM[1:0].
REQ-024 SHALL take store data from fwd_st_M, placed in the low bits and replicated into the selected lane.
REQ-025 SHALL ignore the low address bits for sw/lw and for the unused halves/bytes; no misalignment trap.
REQ-026 SHALL drop stores outside DM_WORDS silently.
REQ-027 SHALL let a load in the cycle after a store to the same word see the stored data.
REQ-028 SHALL still commit a store in M when flush_M is high in the same cycle.

Reset
REQ-029 SHALL on reset clear the E/M register (all outputs read 0, h_M=1).
REQ-030 SHALL on reset clear every memory word to 0 and suppress any store in that cycle.
REQ-031 SHALL give reset priority over flush_M.

Configuration
REQ-032 SHALL, with MEM_WRITE_LOG_EN defined, print "@<pcM>: *<word-aligned addr> <= <merged word>" once per committed in-range store, in simulation only.
REQ-033 SHALL, without MEM_WRITE_LOG_EN, produce no output, with identical RTL behaviour.

Structure
REQ-034 SHALL place opcode constants and DM parameter defaults in the shared header mips_defs.
REQ-035 SHALL place the word array with a 4-bit byte-enable write in sub-module dm_ram; mem_stage holds the E/M register, lane logic and load extension.

Verification
REQ-036 SHALL cover: sw 0x12345678 to 0x10, then lw 0x10 next cycle -> v_R3_MW=0x12345678 with h_M=0.
REQ-037 SHALL cover: sb 0xAB to 0x13, then lb 0x13 -> 0xFFFFFFAB; lbu 0x13 -> 0x000000AB; word 0x10 = 0xAB345678.
REQ-038 SHALL cover: sh 0x8001 to 0x12, then lh -> 0xFFFF8001 and lhu -> 0x00008001.
REQ-039 SHALL cover: store with flush_M=1 in the same cycle -> store committed and next instrM=0.
REQ-040 SHALL cover: sw to DM_BASE+4*DM_WORDS -> no write, and lw there -> 0.
REQ-041 SHALL cover: reset for one cycle after writes -> all words read 0 and all outputs 0.
